// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan receiver: glyph codes, segment
// patterns ({g,f,e,d,c,b,a}, active-high) and the scan FSM state type.
package display_pkg;

    localparam logic [3:0] BLANK   = 4'hA;
    localparam logic [3:0] GLYPH_E = 4'hB;
    localparam logic [3:0] GLYPH_R = 4'hC;
    localparam logic [3:0] GLYPH_O = 4'hD;
    localparam logic [3:0] INVALID = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_R     = 7'b1010000;
    localparam logic [6:0] SEG_O     = 7'b1011100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } scan_state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[1]) idx = 2'd1;
        if (v[2]) idx = 2'd2;
        if (v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/segment_to_code.sv
// Combinational 7-segment to 4-bit code decoder; any pattern outside the
// glyph table decodes to INVALID.
module segment_to_code
    import display_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] code
);

    always_comb begin
        code = INVALID;
        unique case (segments)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_BLANK: code = BLANK;
            SEG_E:     code = GLYPH_E;
            SEG_R:     code = GLYPH_R;
            SEG_O:     code = GLYPH_O;
            default:   code = INVALID;
        endcase
    end

endmodule

// File: rtl/display_scan_receiver.sv
// Rebuilds the four digits shown on a multiplexed 7-segment bus and publishes
// them as a coherent frame, with select/glyph/stall supervision flags.
module display_scan_receiver
    import display_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] segment_in,
    input  logic [3:0] display_n_in,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       frame_valid,
    output logic       select_error,
    output logic       glyph_error,
    output logic       scan_stalled,
    output logic       error_screen
);

    localparam int            CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_DONE = CW'(SETTLE_CYCLES);
    localparam logic [15:0]   STALL_MAX   = 16'(TIMEOUT_CYCLES);

    logic [6:0]    seg_meta, seg_sync;
    logic [3:0]    dn_meta, dn_sync;
    logic [3:0]    sel, sel_prev, held_sel, held_sel_next;
    logic          sel_changed, multi_hot;
    scan_state_t   state, state_next;
    logic [CW-1:0] settle_cnt, settle_cnt_next;
    logic          select_err_next;
    logic          do_sample;
    logic [15:0]   stall_cnt;
    logic [3:0]    slots [4];
    logic [3:0]    captured;
    logic [3:0]    decoded;
    logic [1:0]    idx;
    logic          commit;

    // Both bus inputs are asynchronous; keep them aligned through equal-depth synchronizers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_meta <= '0;
            seg_sync <= '0;
            dn_meta  <= 4'hF;
            dn_sync  <= 4'hF;
        end else begin
            seg_meta <= segment_in;
            seg_sync <= seg_meta;
            dn_meta  <= display_n_in;
            dn_sync  <= dn_meta;
        end
    end

    assign sel         = ~dn_sync;
    assign sel_changed = (sel != sel_prev);
    assign multi_hot   = (sel != 4'b0000) && !is_one_hot(sel);
    assign idx         = sel_index(held_sel);
    assign commit      = (captured == 4'b1111);
    assign scan_stalled = (stall_cnt == STALL_MAX);

    segment_to_code u_decode (
        .segments (seg_sync),
        .code     (decoded)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            settle_cnt   <= '0;
            held_sel     <= '0;
            sel_prev     <= '0;
            select_error <= 1'b0;
        end else begin
            state        <= state_next;
            settle_cnt   <= settle_cnt_next;
            held_sel     <= held_sel_next;
            sel_prev     <= sel;
            select_error <= select_err_next;
        end
    end

    // In IDLE the settle counter times stable multi-hot selects; it saturates so each occurrence flags once.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        held_sel_next   = held_sel;
        select_err_next = 1'b0;
        do_sample       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_one_hot(sel)) begin
                    state_next      = ST_SETTLE;
                    held_sel_next   = sel;
                    settle_cnt_next = '0;
                end else if (sel_changed) begin
                    settle_cnt_next = '0;
                end else if (multi_hot && (settle_cnt < SETTLE_DONE)) begin
                    settle_cnt_next = settle_cnt + 1'b1;
                    select_err_next = (settle_cnt == SETTLE_LAST);
                end
            end
            ST_SETTLE: begin
                if (sel != held_sel) begin
                    settle_cnt_next = '0;
                    if (is_one_hot(sel)) held_sel_next = sel;
                    else                 state_next    = ST_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end else begin
                    settle_cnt_next = settle_cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                do_sample  = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (sel != held_sel) begin
                    settle_cnt_next = '0;
                    if (is_one_hot(sel)) begin
                        state_next    = ST_SETTLE;
                        held_sel_next = sel;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (sel_changed) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // A stall discards the partial frame; committed digits stay on the outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) slots[i] <= BLANK;
            captured    <= '0;
            frame_valid <= 1'b0;
            glyph_error <= 1'b0;
            digit_3     <= BLANK;
            digit_2     <= BLANK;
            digit_1     <= BLANK;
            digit_0     <= BLANK;
        end else begin
            frame_valid <= commit;
            if (scan_stalled) begin
                captured <= '0;
            end else if (do_sample) begin
                slots[idx]    <= decoded;
                captured[idx] <= 1'b1;
            end else if (commit) begin
                captured <= '0;
            end
            if (commit) begin
                digit_3 <= slots[3];
                digit_2 <= slots[2];
                digit_1 <= slots[1];
                digit_0 <= slots[0];
            end
            if (do_sample && (decoded == INVALID)) glyph_error <= 1'b1;
            else if (commit)                       glyph_error <= 1'b0;
        end
    end

    assign error_screen = ({digit_3, digit_2, digit_1, digit_0} ==
                           {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_O});

endmodule

// File: tb/tb_display_scan_receiver.sv
// Scoreboard bench for display_scan_receiver: expected frames are queued as
// digits are scanned, and a monitor checks every frame_valid pulse.
module tb_display_scan_receiver;

    localparam logic [6:0] P_0   = 7'b0111111;
    localparam logic [6:0] P_1   = 7'b0000110;
    localparam logic [6:0] P_2   = 7'b1011011;
    localparam logic [6:0] P_3   = 7'b1001111;
    localparam logic [6:0] P_4   = 7'b1100110;
    localparam logic [6:0] P_5   = 7'b1101101;
    localparam logic [6:0] P_6   = 7'b1111101;
    localparam logic [6:0] P_7   = 7'b0000111;
    localparam logic [6:0] P_8   = 7'b1111111;
    localparam logic [6:0] P_9   = 7'b1101111;
    localparam logic [6:0] P_E   = 7'b1111001;
    localparam logic [6:0] P_R   = 7'b1010000;
    localparam logic [6:0] P_O   = 7'b1011100;
    localparam logic [6:0] P_BAD = 7'b1111110;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [6:0] segment_in;
    logic [3:0] display_n_in;
    logic [3:0] digit_3, digit_2, digit_1, digit_0;
    logic       frame_valid, select_error, glyph_error, scan_stalled, error_screen;

    int total = 0;
    int bad = 0;
    int frames_seen = 0;
    int sel_err_pulses = 0;
    logic [16:0] exp_q [$];

    display_scan_receiver dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .segment_in   (segment_in),
        .display_n_in (display_n_in),
        .digit_3      (digit_3),
        .digit_2      (digit_2),
        .digit_1      (digit_1),
        .digit_0      (digit_0),
        .frame_valid  (frame_valid),
        .select_error (select_error),
        .glyph_error  (glyph_error),
        .scan_stalled (scan_stalled),
        .error_screen (error_screen)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dn, input logic [6:0] seg, input int cycles);
        display_n_in = dn;
        segment_in   = seg;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic showDigit(input int k, input logic [6:0] seg);
        logic [3:0] dn;
        dn = ~(4'b0001 << k);
        applyStimulus(dn, seg, 10);
    endtask

    task automatic scanFrame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                             input logic [6:0] s0, input logic [15:0] exp_digits, input logic exp_err);
        exp_q.push_back({exp_digits, exp_err});
        showDigit(3, s3);
        showDigit(2, s2);
        showDigit(1, s1);
        showDigit(0, s0);
    endtask

    // Monitor: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clock) begin
        logic [16:0] e;
        if (reset_n && select_error) sel_err_pulses++;
        if (reset_n && frame_valid) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_frame: got digits %0h with no frame expected",
                         {digit_3, digit_2, digit_1, digit_0});
            end else begin
                e = exp_q.pop_front();
                checkOutput("frame_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'(e[16:1]));
                checkOutput("frame_error_screen", 32'(error_screen), 32'(e[0]));
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        display_n_in = 4'hF;
        segment_in   = 7'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h0000AAAA);
        checkOutput("reset_flags", 32'({frame_valid, select_error, glyph_error, scan_stalled, error_screen}), 32'h0);
        reset_n = 1'b1;
        applyStimulus(4'hF, 7'b0, 4);

        $display("[TB] T1 basic frame");
        scanFrame(P_2, P_9, P_5, P_0, 16'h2950, 1'b0);

        $display("[TB] T2 error screen then clear");
        scanFrame(P_E, P_R, P_R, P_O, 16'hBCCD, 1'b1);
        scanFrame(P_0, P_0, P_0, P_0, 16'h0000, 1'b0);

        $display("[TB] T3 short select ignored");
        showDigit(3, P_1);
        applyStimulus(4'b1011, P_7, 2);
        showDigit(3, P_3);
        checkOutput("glitch_no_frame", 32'(frames_seen), 32'd3);

        $display("[TB] T4 multi-hot select");
        applyStimulus(4'b0011, P_8, 8);
        applyStimulus(4'hF, 7'b0, 4);
        checkOutput("select_error_pulses", 32'(sel_err_pulses), 32'd1);

        $display("[TB] T5 invalid glyph");
        checkOutput("glyph_clear_before", 32'(glyph_error), 32'd0);
        exp_q.push_back({16'h84F6, 1'b0});
        showDigit(3, P_8);
        showDigit(2, P_4);
        showDigit(1, P_BAD);
        checkOutput("glyph_error_set", 32'(glyph_error), 32'd1);
        showDigit(0, P_6);
        checkOutput("glyph_cleared_by_commit", 32'(glyph_error), 32'd0);

        $display("[TB] T6 stall and mid-frame reset");
        showDigit(3, P_1);
        showDigit(2, P_2);
        applyStimulus(4'b1011, P_2, 65545);
        checkOutput("scan_stalled_set", 32'(scan_stalled), 32'd1);
        checkOutput("digits_held_on_stall", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h000084F6);
        showDigit(1, P_5);
        checkOutput("scan_stalled_cleared", 32'(scan_stalled), 32'd0);
        showDigit(0, P_BAD);
        checkOutput("glyph_before_reset", 32'(glyph_error), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_digits", 32'({digit_3, digit_2, digit_1, digit_0}), 32'h0000AAAA);
        checkOutput("midreset_flags", 32'({frame_valid, select_error, glyph_error, scan_stalled, error_screen}), 32'h0);
        display_n_in = 4'hF;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(4'hF, 7'b0, 4);
        scanFrame(P_1, P_2, P_3, P_4, 16'h1234, 1'b0);
        applyStimulus(4'hF, 7'b0, 6);
        checkOutput("frames_outstanding", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
